alu_arb_2ch: RTL and testbench
==============================

ALU_ARB_2CH -- requirements
Module: alu_arb_2ch

Interface
REQ-001 Parameter RR_INIT, default 0, meaning: channel holding priority after reset (0 or 1).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high; no other clock or reset exists.
REQ-004 req0_valid/req1_valid  input  1 each  requester n presents an operation.
REQ-005 req0_ready/req1_ready  output  1 each  block accepts requester n's operation this cycle.
REQ-006 req0_a, req0_b, req1_a, req1_b  input  8 each  operands per channel.
REQ-007 req0_op/req1_op  input  3 each  ALU opcode per channel (000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT, 110/111 reserved).
REQ-008 alu_a, alu_b  output  8 each  operands to shared ALU; alu_op  output  3  opcode to shared ALU.
REQ-009 alu_result  input  8; alu_carry  input  1; alu_zero  input  1  registered ALU outputs, valid one cycle after operands/opcode are sampled.
REQ-010 rsp_valid  output  1; rsp_ready  input  1  response handshake.
REQ-011 rsp_id  output  1  channel owning response; rsp_result  output  8; rsp_carry  output  1; rsp_zero  output  1; rsp_err  output  1.
REQ-012 op_count  output  16  completed-response counter.

Function
REQ-013 FSM states SHALL be IDLE, ISSUE, CAPT, RESP; transfer SHALL occur only on valid&&ready, per channel.
REQ-014 IDLE: req_ready SHALL be high only for the grant winner; on accept, operands/opcode/channel SHALL be latched; next state ISSUE.
REQ-015 Arbitration: single request wins; both requesting, priority channel wins; after every accept, priority SHALL move to the other channel (round-robin).
REQ-016 alu_a/alu_b/alu_op SHALL be driven from latched values in every state; ISSUE lasts exactly one cycle, then CAPT.
REQ-017 CAPT: alu_result/alu_carry/alu_zero SHALL be captured into rsp_* registers; next state RESP.
REQ-018 RESP: rsp_valid SHALL be high and rsp_* stable until rsp_ready; on handshake return to IDLE and increment op_count.
REQ-019 Both req_ready SHALL be low in ISSUE, CAPT, RESP; minimum accept-to-rsp_valid latency 3 cycles; minimum 4 cycles between accepts.
REQ-020 op_count SHALL wrap 0xFFFF -> 0x0000 without saturation or flag.
REQ-021 A requester deasserting valid before acceptance SHALL lose nothing; priority SHALL not change without an accept.

Reset
REQ-022 Asserting rst SHALL immediately force IDLE, priority = RR_INIT, rsp_valid 0, rsp_id/rsp_result/rsp_carry/rsp_err 0, rsp_zero 1, op_count 0, alu_a/alu_b/alu_op 0, both req_ready 0 while rst high.
REQ-023 Reset mid-operation SHALL discard the in-flight operation with no response and no op_count increment.

Configuration
REQ-024 Macro ALU_ARB_OPCHECK_EN defined: accepted reserved opcode (110/111) SHALL skip ISSUE/CAPT, go directly to RESP with rsp_err 1, rsp_result 0, rsp_carry 0, rsp_zero 1.
REQ-025 Macro undefined: reserved opcodes SHALL be issued normally and rsp_err SHALL be tied 0.

Structure
REQ-026 Opcode constants (ADD..NOT, reserved range) and FSM state encoding SHALL live in shared package alu_pkg, used by this block and the ALU.
REQ-027 Round-robin grant logic SHALL be sub-module rr_arb2 (req[1:0], priority in, grant[1:0] one-hot out); everything else in alu_arb_2ch.

Verification
REQ-028 Only ch0: a=0xF0, b=0x20, op ADD -> rsp_valid 3 cycles after accept, rsp_id 0, result 0x10, carry 1, zero 0.
REQ-029 Both channels continuously requesting, RR_INIT 0 -> grants alternate 0,1,0,1; ch1 SUB 0x05-0x05 -> result 0x00, zero 1, carry 0.
REQ-030 rsp_ready held low 5 cycles in RESP -> rsp_* stable, both req_ready 0, op_count unchanged until handshake.
REQ-031 rst asserted in CAPT -> next cycle IDLE, no response, op_count 0, priority = RR_INIT.
REQ-032 With ALU_ARB_OPCHECK_EN, op 110 -> response 1 cycle after accept, rsp_err 1, result 0x00, zero 1; without macro, rsp_err 0, normal 3-cycle latency.
REQ-033 Preload 65535 completions (or force count) then one more -> op_count reads 0x0000.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU opcode constants and arbiter FSM state encoding.
// Used by alu_arb_2ch and by the shared ALU it drives.
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_NOT  = 3'b101;
    localparam logic [2:0] OP_RSV0 = 3'b110;
    localparam logic [2:0] OP_RSV1 = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_CAPT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    function automatic logic op_reserved(input logic [2:0] op);
        return (op == OP_RSV0) || (op == OP_RSV1);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant: a lone request wins,
// on a tie the channel named by prio wins. Grant is one-hot or zero.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       prio,
    output logic [1:0] grant
);

    always_comb begin
        grant    = 2'b00;
        grant[0] = req[0] & (~req[1] | ~prio);
        grant[1] = req[1] & (~req[0] | prio);
    end

endmodule

// File: rtl/alu_arb_2ch.sv
// Two-channel front end sharing one registered ALU (IDLE/ISSUE/CAPT/RESP).
// Define ALU_ARB_OPCHECK_EN to reject reserved opcodes with rsp_err.
module alu_arb_2ch
    import alu_pkg::*;
#(
    parameter logic RR_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [7:0]  req0_a,
    input  logic [7:0]  req0_b,
    input  logic [7:0]  req1_a,
    input  logic [7:0]  req1_b,
    input  logic [2:0]  req0_op,
    input  logic [2:0]  req1_op,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [2:0]  alu_op,
    input  logic [7:0]  alu_result,
    input  logic        alu_carry,
    input  logic        alu_zero,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [7:0]  rsp_result,
    output logic        rsp_carry,
    output logic        rsp_zero,
    output logic        rsp_err,
    output logic [15:0] op_count
);

    state_e      state_q, state_d;
    logic        prio_q, prio_d;
    logic        id_q, id_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [2:0]  op_q, op_d;
    logic [7:0]  res_q, res_d;
    logic        carry_q, carry_d;
    logic        zero_q, zero_d;
    logic [15:0] op_count_q, op_count_d;
    logic [1:0]  grant;
    logic [1:0]  ready;
    logic [7:0]  sel_a, sel_b;
    logic [2:0]  sel_op;
`ifdef ALU_ARB_OPCHECK_EN
    logic        err_q, err_d;
`endif

    rr_arb2 u_arb (
        .req   ({req1_valid, req0_valid}),
        .prio  (prio_q),
        .grant (grant)
    );

    // Readiness is withheld outside IDLE and while reset is held.
    assign ready      = grant & {2{(state_q == ST_IDLE) & ~rst}};
    assign req0_ready = ready[0];
    assign req1_ready = ready[1];

    assign sel_a  = ready[1] ? req1_a  : req0_a;
    assign sel_b  = ready[1] ? req1_b  : req0_b;
    assign sel_op = ready[1] ? req1_op : req0_op;

    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        id_d       = id_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        res_d      = res_q;
        carry_d    = carry_q;
        zero_d     = zero_q;
        op_count_d = op_count_q;
`ifdef ALU_ARB_OPCHECK_EN
        err_d      = err_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (|ready) begin
                    a_d     = sel_a;
                    b_d     = sel_b;
                    op_d    = sel_op;
                    id_d    = ready[1];
                    prio_d  = ~ready[1];
                    state_d = ST_ISSUE;
`ifdef ALU_ARB_OPCHECK_EN
                    if (op_reserved(sel_op)) begin
                        res_d   = 8'h00;
                        carry_d = 1'b0;
                        zero_d  = 1'b1;
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end
`endif
                end
            end
            ST_ISSUE: state_d = ST_CAPT;
            ST_CAPT: begin
                res_d   = alu_result;
                carry_d = alu_carry;
                zero_d  = alu_zero;
`ifdef ALU_ARB_OPCHECK_EN
                err_d   = 1'b0;
`endif
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    op_count_d = op_count_q + 16'd1;
                    state_d    = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            prio_q     <= RR_INIT;
            id_q       <= 1'b0;
            a_q        <= 8'h00;
            b_q        <= 8'h00;
            op_q       <= 3'b000;
            res_q      <= 8'h00;
            carry_q    <= 1'b0;
            zero_q     <= 1'b1;
            op_count_q <= 16'h0000;
`ifdef ALU_ARB_OPCHECK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            id_q       <= id_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            res_q      <= res_d;
            carry_q    <= carry_d;
            zero_q     <= zero_d;
            op_count_q <= op_count_d;
`ifdef ALU_ARB_OPCHECK_EN
            err_q      <= err_d;
`endif
        end
    end

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_op     = op_q;
    assign rsp_valid  = (state_q == ST_RESP);
    assign rsp_id     = id_q;
    assign rsp_result = res_q;
    assign rsp_carry  = carry_q;
    assign rsp_zero   = zero_q;
    assign op_count   = op_count_q;
`ifdef ALU_ARB_OPCHECK_EN
    assign rsp_err    = err_q;
`else
    assign rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arb_2ch.sv
// Bench for alu_arb_2ch with a registered ALU model on its ALU port.
// Honours ALU_ARB_OPCHECK_EN for the reserved-opcode case.
module tb_alu_arb_2ch;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [7:0]  req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic [2:0]  req0_op = 0, req1_op = 0;
    logic [7:0]  alu_a, alu_b;
    logic [2:0]  alu_op;
    logic [7:0]  alu_result = 8'h00;
    logic        alu_carry = 1'b0, alu_zero = 1'b1;
    logic        rsp_valid, rsp_ready = 1'b0;
    logic        rsp_id, rsp_carry, rsp_zero, rsp_err;
    logic [7:0]  rsp_result;
    logic [15:0] op_count;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    alu_arb_2ch dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_a(req1_a), .req1_b(req1_b),
        .req0_op(req0_op), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_carry(alu_carry),
        .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
        .rsp_err(rsp_err), .op_count(op_count)
    );

    // {carry, result}; SUB carry means borrow; reserved ops yield A5.
    function automatic logic [8:0] alu_ref(input logic [7:0] a,
                                           input logic [7:0] b,
                                           input logic [2:0] op);
        int s;
        case (op)
            3'd0: begin s = int'(a) + int'(b); return {s > 255, 8'(s)}; end
            3'd1: return {a < b, 8'(int'(a) - int'(b))};
            3'd2: return {1'b0, a & b};
            3'd3: return {1'b0, a | b};
            3'd4: return {1'b0, a ^ b};
            3'd5: return {1'b0, ~a};
            default: return {1'b0, 8'hA5};
        endcase
    endfunction

    always @(posedge clk) begin
        logic [8:0] r;
        r = alu_ref(alu_a, alu_b, alu_op);
        alu_carry  <= r[8];
        alu_result <= r[7:0];
        alu_zero   <= (r[7:0] == 8'h00);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic run_op(input logic ch, input logic [7:0] a,
                          input logic [7:0] b, input logic [2:0] op,
                          output int lat, output logic id,
                          output logic [7:0] res, output logic c,
                          output logic z, output logic e);
        int n;
        lat = -1; id = 0; res = 0; c = 0; z = 0; e = 0;
        @(negedge clk);
        if (ch) begin
            req1_valid = 1; req1_a = a; req1_b = b; req1_op = op;
        end else begin
            req0_valid = 1; req0_a = a; req0_b = b; req0_op = op;
        end
        #1;
        n = 0;
        while (!(ch ? req1_ready : req0_ready) && n < 20) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 20) begin
            chk("accept_timeout", 1, 0);
            req0_valid = 0; req1_valid = 0;
            return;
        end
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        lat = 0;
        do begin
            @(negedge clk); lat++;
        end while (!rsp_valid && lat < 20);
        id = rsp_id; res = rsp_result; c = rsp_carry;
        z = rsp_zero; e = rsp_err;
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
        if (rsp_valid === 1'b0) exp_cnt++;
    endtask

    typedef struct {
        logic       ch;
        logic [7:0] a, b;
        logic [2:0] op;
        logic [7:0] r;
        logic       c, z;
    } vec_t;

    vec_t vt[8];

    initial begin
        int lat;
        logic id, c, z, e;
        logic [7:0] res;
        int grants[$];
        int gcyc[$];
        int cyc;
        logic seen1;

        vt[0] = '{0, 8'hF0, 8'h20, OP_ADD, 8'h10, 1, 0};
        vt[1] = '{1, 8'h05, 8'h05, OP_SUB, 8'h00, 0, 1};
        vt[2] = '{0, 8'h03, 8'h05, OP_SUB, 8'hFE, 1, 0};
        vt[3] = '{1, 8'hCC, 8'h0F, OP_AND, 8'h0C, 0, 0};
        vt[4] = '{0, 8'hA0, 8'h05, OP_OR,  8'hA5, 0, 0};
        vt[5] = '{1, 8'hFF, 8'hFF, OP_XOR, 8'h00, 0, 1};
        vt[6] = '{0, 8'h0F, 8'h00, OP_NOT, 8'hF0, 0, 0};
        vt[7] = '{1, 8'hFF, 8'h01, OP_ADD, 8'h00, 1, 1};

        // reset state, with both requesters asking
        req0_valid = 1; req1_valid = 1;
        @(negedge clk); @(negedge clk); #1;
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_zero", rsp_zero, 1);
        chk("rst_rsp_misc", {rsp_id, rsp_carry, rsp_err, rsp_result}, 0);
        chk("rst_op_count", op_count, 0);
        chk("rst_alu", {alu_a, alu_b, alu_op}, 0);
        req0_valid = 0; req1_valid = 0;
        rst = 0;

        foreach (vt[i]) begin
            run_op(vt[i].ch, vt[i].a, vt[i].b, vt[i].op,
                   lat, id, res, c, z, e);
            chk($sformatf("vec%0d_lat", i), lat, 3);
            chk($sformatf("vec%0d_id", i), id, vt[i].ch);
            chk($sformatf("vec%0d_res", i), res, vt[i].r);
            chk($sformatf("vec%0d_cz", i), {c, z}, {vt[i].c, vt[i].z});
            chk($sformatf("vec%0d_err", i), e, 0);
            chk($sformatf("vec%0d_cnt", i), op_count, 16'(exp_cnt));
        end

        for (int i = 0; i < 30; i++) begin
            logic       rch;
            logic [7:0] ra, rb;
            logic [2:0] rop;
            logic [8:0] x;
            rch = 1'($urandom_range(0, 1));
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rop = 3'($urandom_range(0, 5));
            x   = alu_ref(ra, rb, rop);
            run_op(rch, ra, rb, rop, lat, id, res, c, z, e);
            chk($sformatf("rnd%0d_lat", i), lat, 3);
            chk($sformatf("rnd%0d_id", i), id, rch);
            chk($sformatf("rnd%0d_res", i), {c, res}, x);
            chk($sformatf("rnd%0d_z", i), z, x[7:0] == 0);
            chk($sformatf("rnd%0d_cnt", i), op_count, 16'(exp_cnt));
        end

        // stall in RESP with both requesters waiting
        @(negedge clk);
        req0_valid = 1; req0_a = 8'h3C; req0_b = 8'h0F; req0_op = OP_XOR;
        #1;
        chk("stall_accept", req0_ready, 1);
        @(posedge clk); #1;
        req0_valid = 0;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!rsp_valid && cyc < 20);
        chk("stall_lat", cyc, 3);
        req0_valid = 1; req1_valid = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            chk("stall_valid", rsp_valid, 1);
            chk("stall_res", {rsp_id, rsp_result}, {1'b0, 8'h33});
            chk("stall_ready", {req1_ready, req0_ready}, 0);
            chk("stall_cnt", op_count, 16'(exp_cnt));
            chk("stall_alu", {alu_a, alu_op}, {8'h3C, OP_XOR});
        end
        req0_valid = 0; req1_valid = 0;
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
        exp_cnt++;
        chk("stall_done_cnt", op_count, 16'(exp_cnt));
        chk("stall_done_valid", rsp_valid, 0);

        // reserved opcode
        run_op(1, 8'h12, 8'h34, OP_RSV0, lat, id, res, c, z, e);
`ifdef ALU_ARB_OPCHECK_EN
        chk("rsv_lat", lat, 1);
        chk("rsv_rsp", {e, c, z, res}, {1'b1, 1'b0, 1'b1, 8'h00});
`else
        chk("rsv_lat", lat, 3);
        chk("rsv_rsp", {e, c, z, res}, {1'b0, 1'b0, 1'b0, 8'hA5});
`endif
        chk("rsv_id", id, 1);

        // round-robin alternation from a fresh reset
        @(negedge clk); rst = 1; #1; rst = 0; exp_cnt = 0;
        @(negedge clk);
        req0_valid = 1; req0_a = 8'h01; req0_b = 8'h02; req0_op = OP_ADD;
        req1_valid = 1; req1_a = 8'h05; req1_b = 8'h05; req1_op = OP_SUB;
        rsp_ready = 1;
        cyc = 0; seen1 = 0;
        while (grants.size() < 4 && cyc < 40) begin
            #1;
            if (req0_ready && req1_ready) chk("rr_both_ready", 1, 0);
            if (req0_ready) begin grants.push_back(0); gcyc.push_back(cyc); end
            else if (req1_ready) begin grants.push_back(1); gcyc.push_back(cyc); end
            if (rsp_valid && rsp_id && !seen1) begin
                seen1 = 1;
                chk("rr_ch1_res", {rsp_carry, rsp_zero, rsp_result},
                    {1'b0, 1'b1, 8'h00});
            end
            @(negedge clk); cyc++;
        end
        req0_valid = 0; req1_valid = 0;
        chk("rr_count", grants.size(), 4);
        for (int k = 0; k < grants.size(); k++)
            chk($sformatf("rr_grant%0d", k), grants[k], k % 2);
        for (int k = 1; k < gcyc.size(); k++)
            chk($sformatf("rr_gap%0d", k), gcyc[k] - gcyc[k-1], 4);
        chk("rr_ch1_seen", seen1, 1);
        repeat (6) @(negedge clk);
        rsp_ready = 0;
        chk("rr_cnt", op_count, 4);

        // reset while in CAPT; ch0 in flight moves priority to ch1
        exp_cnt = 0;
        @(negedge clk); rst = 1; #1; rst = 0;
        @(negedge clk);
        req0_valid = 1; req0_a = 8'h11; req0_b = 8'h22; req0_op = OP_ADD;
        #1;
        chk("rc_accept", req0_ready, 1);
        @(posedge clk); #1;
        req0_valid = 0;
        @(negedge clk); @(negedge clk);
        chk("rc_capt_novalid", rsp_valid, 0);
        req0_valid = 1; req1_valid = 1;
        #1 rst = 1; #1;
        chk("rc_rst_valid", rsp_valid, 0);
        chk("rc_rst_ready", {req1_ready, req0_ready}, 0);
        chk("rc_rst_alu", {alu_a, alu_b, alu_op}, 0);
        @(negedge clk); rst = 0; #1;
        chk("rc_prio", {req1_ready, req0_ready}, 2'b01);
        req0_valid = 0; req1_valid = 0;
        seen1 = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rsp_valid) seen1 = 1;
        end
        chk("rc_no_rsp", seen1, 0);
        chk("rc_cnt", op_count, 0);

        // counter wrap
        @(negedge clk);
        force dut.op_count_q = 16'hFFFE;
        #1 release dut.op_count_q;
        #1 chk("wrap_pre", op_count, 16'hFFFE);
        run_op(0, 8'h01, 8'h01, OP_AND, lat, id, res, c, z, e);
        chk("wrap_ffff", op_count, 16'hFFFF);
        run_op(1, 8'h01, 8'h01, OP_OR, lat, id, res, c, z, e);
        chk("wrap_zero", op_count, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
